// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag controller for a 2**ADDR_W-word FIFO storage bank.
// Accept decisions use the registered full/empty state; every flag is registered from count_next.
module fifo_ptr_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int AFULL_TH  = 240,
    parameter int AEMPTY_TH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              clr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] waddr,
    output logic              mem_re,
    output logic [ADDR_W-1:0] raddr,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              udf
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C   = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C  = (ADDR_W + 1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] ONE_C     = (ADDR_W + 1)'(1);

    logic [ADDR_W:0] wptr_reg, wptr_next;
    logic [ADDR_W:0] rptr_reg, rptr_next;
    logic [ADDR_W:0] count_reg, count_next;
    logic            full_reg, full_next;
    logic            empty_reg, empty_next;
    logic            afull_reg, afull_next;
    logic            aempty_reg, aempty_next;
    logic            ovf_reg, ovf_next;
    logic            udf_reg, udf_next;
    logic            rd_valid_reg;

    logic wa;
    logic ra;

    assign wa = wr_req & ~full_reg & ~clr;
    assign ra = rd_req & ~empty_reg & ~clr;

    // Strobes are gated by rst_n so storage is never written while reset is held.
    assign mem_we = wa & rst_n;
    assign mem_re = ra & rst_n;

    always_comb begin
        wptr_next   = wptr_reg;
        rptr_next   = rptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        udf_next    = udf_reg;
        if (clr) begin
            wptr_next  = '0;
            rptr_next  = '0;
            count_next = '0;
            ovf_next   = 1'b0;
            udf_next   = 1'b0;
        end else begin
            if (wa) wptr_next = wptr_reg + ONE_C;
            if (ra) rptr_next = rptr_reg + ONE_C;
            if (wa && !ra) count_next = count_reg + ONE_C;
            if (ra && !wa) count_next = count_reg - ONE_C;
            ovf_next = ovf_reg | (wr_req & full_reg);
            udf_next = udf_reg | (rd_req & empty_reg);
        end
        full_next   = (count_next == DEPTH_C);
        empty_next  = (count_next == '0);
        afull_next  = (count_next >= AFULL_C);
        aempty_next = (count_next <= AEMPTY_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            afull_reg    <= 1'b0;
            aempty_reg   <= 1'b1;
            ovf_reg      <= 1'b0;
            udf_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            count_reg    <= count_next;
            full_reg     <= full_next;
            empty_reg    <= empty_next;
            afull_reg    <= afull_next;
            aempty_reg   <= aempty_next;
            ovf_reg      <= ovf_next;
            udf_reg      <= udf_next;
            rd_valid_reg <= ra;
        end
    end

    assign waddr        = wptr_reg[ADDR_W-1:0];
    assign raddr        = rptr_reg[ADDR_W-1:0];
    assign count        = count_reg;
    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = afull_reg;
    assign almost_empty = aempty_reg;
    assign ovf          = ovf_reg;
    assign udf          = udf_reg;
    assign rd_valid     = rd_valid_reg;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl: a vector table for short sequences plus
// hand-written sequences for fill, wrap-around, flush and asynchronous reset.
module tb_fifo_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic       clr = 1'b0;
    logic       mem_we;
    logic [7:0] waddr;
    logic       mem_re;
    logic [7:0] raddr;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [8:0] count;
    logic       ovf;
    logic       udf;

    int checks = 0;
    int failures = 0;

    fifo_ptr_ctrl #(.ADDR_W(8), .AFULL_TH(240), .AEMPTY_TH(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req), .clr(clr),
        .mem_we(mem_we), .waddr(waddr), .mem_re(mem_re), .raddr(raddr),
        .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Visible-state invariants, sampled on the falling edge when registers are stable.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_count_ptrdiff", int'(count[7:0]), int'(8'(waddr - raddr)));
            chk("inv_full_count", int'(full), int'(count == 9'd256));
            chk("inv_empty_count", int'(empty), int'(count == 9'd0));
            if (full || empty) chk("inv_addr_equal", int'(waddr), int'(raddr));
        end
    end

    typedef struct {
        logic       wr, rd, cl;
        logic       we, re;
        logic [7:0] wa, ra;
        logic [8:0] cnt;
        logic       emp, ov, ud, rv;
    } vec_t;

    vec_t vecs[10];

    // Drive inputs just after a rising edge, sample strobes before the next edge.
    logic s_we, s_re;
    logic [7:0] s_wa, s_ra;

    task automatic step(input logic w, input logic r, input logic c);
        wr_req = w; rd_req = r; clr = c;
        #1;
        s_we = mem_we; s_re = mem_re; s_wa = waddr; s_ra = raddr;
        @(posedge clk); #1;
        wr_req = 1'b0; rd_req = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{1'b0,1'b0,1'b0, 1'b0,1'b0, 8'd0,8'd0, 9'd0, 1'b1,1'b0,1'b0,1'b0};
        vecs[1] = '{1'b0,1'b1,1'b0, 1'b0,1'b0, 8'd0,8'd0, 9'd0, 1'b1,1'b0,1'b1,1'b0};
        vecs[2] = '{1'b1,1'b0,1'b0, 1'b1,1'b0, 8'd0,8'd0, 9'd1, 1'b0,1'b0,1'b1,1'b0};
        vecs[3] = '{1'b1,1'b0,1'b0, 1'b1,1'b0, 8'd1,8'd0, 9'd2, 1'b0,1'b0,1'b1,1'b0};
        vecs[4] = '{1'b1,1'b1,1'b0, 1'b1,1'b1, 8'd2,8'd0, 9'd2, 1'b0,1'b0,1'b1,1'b1};
        vecs[5] = '{1'b0,1'b1,1'b0, 1'b0,1'b1, 8'd3,8'd1, 9'd1, 1'b0,1'b0,1'b1,1'b1};
        vecs[6] = '{1'b0,1'b0,1'b0, 1'b0,1'b0, 8'd3,8'd2, 9'd1, 1'b0,1'b0,1'b1,1'b0};
        vecs[7] = '{1'b1,1'b1,1'b1, 1'b0,1'b0, 8'd3,8'd2, 9'd0, 1'b1,1'b0,1'b0,1'b0};
        vecs[8] = '{1'b1,1'b0,1'b0, 1'b1,1'b0, 8'd0,8'd0, 9'd1, 1'b0,1'b0,1'b0,1'b0};
        vecs[9] = '{1'b0,1'b1,1'b0, 1'b0,1'b1, 8'd1,8'd0, 9'd0, 1'b1,1'b0,1'b0,1'b1};

        // Reset then idle 5 cycles
        do_reset();
        repeat (5) step(1'b0, 1'b0, 1'b0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_aempty", int'(almost_empty), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_raddr", int'(raddr), 0);
        chk("rst_we", int'(s_we), 0);
        chk("rst_re", int'(s_re), 0);
        chk("rst_full", int'(full), 0);

        // Table-driven short sequences
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].cl);
            chk($sformatf("v%0d_we", i), int'(s_we), int'(vecs[i].we));
            chk($sformatf("v%0d_re", i), int'(s_re), int'(vecs[i].re));
            chk($sformatf("v%0d_waddr", i), int'(s_wa), int'(vecs[i].wa));
            chk($sformatf("v%0d_raddr", i), int'(s_ra), int'(vecs[i].ra));
            chk($sformatf("v%0d_count", i), int'(count), int'(vecs[i].cnt));
            chk($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].emp));
            chk($sformatf("v%0d_ovf", i), int'(ovf), int'(vecs[i].ov));
            chk($sformatf("v%0d_udf", i), int'(udf), int'(vecs[i].ud));
            chk($sformatf("v%0d_rdvalid", i), int'(rd_valid), int'(vecs[i].rv));
        end

        // Fill 256 words
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk($sformatf("fill%0d_we", i), int'(s_we), 1);
            chk($sformatf("fill%0d_waddr", i), int'(s_wa), i);
            if (i == 15) chk("fill16_aempty", int'(almost_empty), 1);
            if (i == 16) chk("fill17_aempty", int'(almost_empty), 0);
            if (i == 238) chk("fill239_afull", int'(almost_full), 0);
            if (i == 239) chk("fill240_afull", int'(almost_full), 1);
            if (i == 254) chk("fill255_full", int'(full), 0);
        end
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 256);
        chk("fill_ovf_pre", int'(ovf), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("w257_we", int'(s_we), 0);
        chk("w257_ovf", int'(ovf), 1);
        chk("w257_count", int'(count), 256);

        // Write+read while full: read wins
        step(1'b1, 1'b1, 1'b0);
        chk("fullrw_re", int'(s_re), 1);
        chk("fullrw_we", int'(s_we), 0);
        chk("fullrw_raddr", int'(s_ra), 0);
        chk("fullrw_rdvalid", int'(rd_valid), 1);
        chk("fullrw_count", int'(count), 255);
        chk("fullrw_full", int'(full), 0);
        chk("fullrw_ovf", int'(ovf), 1);

        // Wrap-around: 30 rounds of write 10 / read 10
        step(1'b0, 1'b0, 1'b1);
        chk("flush_count", int'(count), 0);
        chk("flush_ovf", int'(ovf), 0);
        for (int r = 0; r < 30; r++) begin
            repeat (10) step(1'b1, 1'b0, 1'b0);
            repeat (10) step(1'b0, 1'b1, 1'b0);
            chk($sformatf("round%0d_empty", r), int'(empty), 1);
            chk($sformatf("round%0d_count", r), int'(count), 0);
        end
        chk("wrap_waddr", int'(waddr), 44);
        chk("wrap_raddr", int'(raddr), 44);
        chk("wrap_ovf", int'(ovf), 0);
        chk("wrap_udf", int'(udf), 0);

        // Write+read while empty: write wins
        step(1'b1, 1'b1, 1'b0);
        chk("emptyrw_we", int'(s_we), 1);
        chk("emptyrw_waddr", int'(s_wa), 44);
        chk("emptyrw_re", int'(s_re), 0);
        chk("emptyrw_udf", int'(udf), 1);
        chk("emptyrw_count", int'(count), 1);
        chk("emptyrw_rdvalid", int'(rd_valid), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("emptyrd_re", int'(s_re), 1);
        chk("emptyrd_raddr", int'(s_ra), 44);
        chk("emptyrd_rdvalid", int'(rd_valid), 1);
        chk("emptyrd_count", int'(count), 0);

        // Reach count=100 with ovf set, then clr with requests
        step(1'b0, 1'b0, 1'b1);
        repeat (256) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (156) step(1'b0, 1'b1, 1'b0);
        chk("pre_clr_count", int'(count), 100);
        chk("pre_clr_ovf", int'(ovf), 1);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_we", int'(s_we), 0);
        chk("clr_re", int'(s_re), 0);
        chk("clr_count", int'(count), 0);
        chk("clr_empty", int'(empty), 1);
        chk("clr_aempty", int'(almost_empty), 1);
        chk("clr_ovf", int'(ovf), 0);
        chk("clr_rdvalid", int'(rd_valid), 0);

        // Asynchronous reset in the middle of a write burst
        repeat (5) step(1'b1, 1'b0, 1'b0);
        wr_req = 1'b1; rd_req = 1'b1;
        #1;
        chk("burst_we", int'(mem_we), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_we", int'(mem_we), 0);
        chk("arst_re", int'(mem_re), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_waddr", int'(waddr), 0);
        chk("arst_raddr", int'(raddr), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_aempty", int'(almost_empty), 1);
        chk("arst_full", int'(full), 0);
        chk("arst_rdvalid", int'(rd_valid), 0);
        wr_req = 1'b0; rd_req = 1'b0;
        do_reset();
        chk("post_rst_count", int'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
